if_fetch_queue: RTL

// - Parametrised instruction-fetch stage: own PC, issues requests to a 1-cycle-latency synchronous imem, buffers returned
//   {pc,inst} pairs in a DEPTH-entry prefetch FIFO, hands them to ID over a valid/ready handshake.
// - Sits between imem and ID; EX redirects (taken branch/jump) flush the queue and drop any in-flight fetch.

---
 rtl/if_fetch_queue_if.sv | 25 ++
 rtl/if_fetch_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: EX redirect, imem request/response and the ID valid/ready handshake.
// master = fetch stage, slave = surrounding pipeline/imem.
interface if_fetch_queue_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic [XLEN-1:0] i_imem_data;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_inst;
  logic [XLEN-1:0] o_pc;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_data, i_ready,
    output o_imem_req, o_imem_addr, o_valid, o_inst, o_pc
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_data, i_ready,
    input  o_imem_req, o_imem_addr, o_valid, o_inst, o_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: own PC, 1-cycle imem, DEPTH-entry prefetch FIFO toward ID.
// Optional IF_PERF_CNT_EN adds o_fetch_cnt / o_flush_cnt performance counters.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  if_fetch_queue_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      o_fetch_cnt,
  output logic [31:0]      o_flush_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic            req;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [CW:0]     used;

  // Credit-based request (queued + in flight never exceeds DEPTH), push and pop qualification.
  // Reset gates the request so the imem sees no fetch while the stage is held in reset.
  always_comb begin
    used       = {1'b0, count} + (CW+1)'(inflight);
    head_valid = (count != '0);
    req        = i_rst && !bus.i_redirect && (used < DEPTH_W);
    push       = inflight && !bus.i_redirect;
    pop        = head_valid && bus.i_ready && !bus.i_redirect;
  end

  // PC, in-flight tracking and FIFO pointers/occupancy; a redirect overrides everything else.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (bus.i_redirect) begin
      pc       <= bus.i_redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (req) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
      inflight <= req;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.i_imem_data;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

  // Outputs: registered head toward ID (zero when empty), PC register toward imem.
  always_comb begin
    bus.o_imem_req  = req;
    bus.o_imem_addr = pc;
    bus.o_valid     = head_valid;
    bus.o_inst      = head_valid ? inst_mem[rd_ptr] : '0;
    bus.o_pc        = head_valid ? pc_mem[rd_ptr]   : '0;
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: pushes accepted, and entries (queued + in flight) discarded per redirect.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fetch_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (push) o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (bus.i_redirect) o_flush_cnt <= o_flush_cnt + 32'(count) + 32'(inflight);
    end
  end
`endif

endmodule
